// File: rtl/byte_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words are buffered in a DEPTH-entry
// FIFO and streamed one bit per cycle over a valid/ready serial port.
//
// state   | meaning
// S_IDLE  | shifter empty, output idle; loads the FIFO head when one exists
// S_SHIFT | shifter holds a word; presents one bit per cycle until consumed
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [WIDTH-1:0]         io_in_bits,
  output logic                     io_out,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic                     io_out_last,
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;

  logic w_push;
  logic w_pop;
  logic w_nonempty;
  logic w_last;

  assign w_nonempty  = (r_count != '0);
  assign w_last      = (r_bitcnt == BW'(WIDTH - 1));
  // Full means not ready, even if the shifter would pop in the same cycle.
  assign io_in_ready = !reset && (r_count != CW'(DEPTH));
  assign w_push      = io_in_valid && io_in_ready;

  always_comb begin
    w_pop = 1'b0;
    if (r_state == S_IDLE) w_pop = w_nonempty;
    else                   w_pop = io_out_ready && w_last && w_nonempty;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= io_in_bits;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shreg  <= r_mem[r_rptr];
            r_bitcnt <= '0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (io_out_ready) begin
            if (!w_last) begin
              r_shreg  <= MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shreg[WIDTH-1:1]};
              r_bitcnt <= r_bitcnt + 1'b1;
            end else if (w_nonempty) begin
              // Chain straight into the next word so the stream has no bubble.
              r_shreg  <= r_mem[r_rptr];
              r_bitcnt <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_out_valid = !reset && (r_state == S_SHIFT);
  assign io_out       = io_out_valid && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
  assign io_out_last  = io_out_valid && w_last;
  assign io_count     = r_count;

endmodule
